// File: rtl/rgbyuv_pkg.sv
// Shared types for the RGB->YUV converter scheduler.
// Skin-window bounds are used only with RGBYUV_SCHED_SKIN_EN.
package rgbyuv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic valid;
    src_e src;
  } tag_t;

  localparam logic [7:0] SKIN_U_LO = 8'd73;
  localparam logic [7:0] SKIN_U_HI = 8'd122;
  localparam logic [7:0] SKIN_V_LO = 8'd132;
  localparam logic [7:0] SKIN_V_HI = 8'd173;

  function automatic logic is_skin(
    input logic [7:0] u,
    input logic [7:0] v
  );
    return (u >= SKIN_U_LO) && (u <= SKIN_U_HI) &&
           (v >= SKIN_V_LO) && (v <= SKIN_V_HI);
  endfunction

endpackage

// File: rtl/rgbyuv_sched_if.sv
// Source handshake and result bus of rgbyuv_sched.
// Skin flags exist only with RGBYUV_SCHED_SKIN_EN.
interface rgbyuv_sched_if;
  logic        a_valid;
  logic        b_valid;
  logic [53:0] a_rgb;
  logic [53:0] b_rgb;
  logic        a_ready;
  logic        b_ready;
  logic        ya_valid;
  logic        yb_valid;
  logic [23:0] ya_yuv;
  logic [23:0] yb_yuv;
`ifdef RGBYUV_SCHED_SKIN_EN
  logic        ya_skin;
  logic        yb_skin;
`endif

  modport master (
    output a_valid, b_valid, a_rgb, b_rgb,
    input  a_ready, b_ready,
    input  ya_valid, yb_valid, ya_yuv, yb_yuv
`ifdef RGBYUV_SCHED_SKIN_EN
    ,
    input  ya_skin, yb_skin
`endif
  );

  modport slave (
    input  a_valid, b_valid, a_rgb, b_rgb,
    output a_ready, b_ready,
    output ya_valid, yb_valid, ya_yuv, yb_yuv
`ifdef RGBYUV_SCHED_SKIN_EN
    ,
    output ya_skin, yb_skin
`endif
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; pointer moves only on a transfer.
// Readies are combinational from valids and the pointer.
module rr_arb2
  import rgbyuv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready
);

  src_e ptr_q;

  assign a_ready = en & a_valid &
                   (~b_valid | (ptr_q == SRC_A));
  assign b_ready = en & b_valid &
                   (~a_valid | (ptr_q == SRC_B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= SRC_A;
    else if (a_ready)
      ptr_q <= SRC_B;
    else if (b_ready)
      ptr_q <= SRC_A;
  end

endmodule

// File: rtl/rgbyuv_sched.sv
// Schedules two RGB sources onto one shared YUV converter.
// Define RGBYUV_SCHED_SKIN_EN for skin flags and skin counters.
module rgbyuv_sched
  import rgbyuv_pkg::*;
#(
  parameter int LAT = 4,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rgbyuv_sched_if.slave s,
  output logic [17:0]   cv_red,
  output logic [17:0]   cv_grn,
  output logic [17:0]   cv_blu,
  input  logic [7:0]    cv_y,
  input  logic [7:0]    cv_u,
  input  logic [7:0]    cv_v,
  input  logic          flush,
  output logic          flush_done,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic          busy
`ifdef RGBYUV_SCHED_SKIN_EN
  ,
  output logic [CW-1:0] skin_a,
  output logic [CW-1:0] skin_b
`endif
);

  state_e st_q, st_d;
  tag_t   tag_q [0:LAT];
  tag_t   tag_o;
  logic   en, xfer, head_busy;

  assign en = rst_n & (st_q == RUN) & ~flush;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a_valid (s.a_valid),
    .b_valid (s.b_valid),
    .a_ready (s.a_ready),
    .b_ready (s.b_ready)
  );

  assign xfer = s.a_ready | s.b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      {cv_red, cv_grn, cv_blu} <= '0;
    else if (s.b_ready)
      {cv_red, cv_grn, cv_blu} <= s.b_rgb;
    else if (s.a_ready)
      {cv_red, cv_grn, cv_blu} <= s.a_rgb;
  end

  // stage 0 rides with cv_*; stage LAT lines up with the converter result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++)
        tag_q[i] <= '{valid: 1'b0, src: SRC_A};
    end else begin
      tag_q[0] <= '{valid: xfer,
                    src: s.b_ready ? SRC_B : SRC_A};
      for (int i = 1; i <= LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    head_busy = 1'b0;
    for (int i = 0; i < LAT; i++)
      head_busy = head_busy | tag_q[i].valid;
  end

  assign tag_o      = tag_q[LAT];
  assign busy       = head_busy | tag_o.valid;
  assign s.ya_valid = tag_o.valid & (tag_o.src == SRC_A);
  assign s.yb_valid = tag_o.valid & (tag_o.src == SRC_B);
  assign s.ya_yuv   = {cv_y, cv_u, cv_v};
  assign s.yb_yuv   = {cv_y, cv_u, cv_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st_q <= RUN;
    else
      st_q <= st_d;
  end

  // leave DRAIN as the last result is on the output
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      RUN:     if (flush)      st_d = DRAIN;
      DRAIN:   if (!head_busy) st_d = DONE;
      DONE:    if (!flush)     st_d = RUN;
      default:                 st_d = RUN;
    endcase
  end

  assign flush_done = (st_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (s.ya_valid) cnt_a <= cnt_a + CW'(1);
      if (s.yb_valid) cnt_b <= cnt_b + CW'(1);
    end
  end

`ifdef RGBYUV_SCHED_SKIN_EN
  logic skin_hit;

  assign skin_hit  = is_skin(cv_u, cv_v);
  assign s.ya_skin = s.ya_valid & skin_hit;
  assign s.yb_skin = s.yb_valid & skin_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skin_a <= '0;
      skin_b <= '0;
    end else begin
      if (s.ya_skin) skin_a <= skin_a + CW'(1);
      if (s.yb_skin) skin_b <= skin_b + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rgbyuv_sched.sv
// Scoreboard bench for rgbyuv_sched with a fixed-latency converter model.
// Skin checks are compiled in with RGBYUV_SCHED_SKIN_EN.
module tb_rgbyuv_sched;

  localparam int LAT = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgbyuv_sched_if bus();

  logic [17:0]   cv_red, cv_grn, cv_blu;
  logic [7:0]    cv_y, cv_u, cv_v;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          busy;
`ifdef RGBYUV_SCHED_SKIN_EN
  logic [CW-1:0] skin_a, skin_b;
`endif

  rgbyuv_sched #(.LAT(LAT), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus),
    .cv_red     (cv_red),
    .cv_grn     (cv_grn),
    .cv_blu     (cv_blu),
    .cv_y       (cv_y),
    .cv_u       (cv_u),
    .cv_v       (cv_v),
    .flush      (flush),
    .flush_done (flush_done),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .busy       (busy)
`ifdef RGBYUV_SCHED_SKIN_EN
    ,
    .skin_a     (skin_a),
    .skin_b     (skin_b)
`endif
  );

  // converter model: low bytes of r/g/b appear LAT cycles after cv_*
  logic [23:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= {cv_red[7:0], cv_grn[7:0], cv_blu[7:0]};
    for (int i = 1; i < LAT; i++)
      hist[i] <= hist[i-1];
  end
  assign {cv_y, cv_u, cv_v} = hist[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic [23:0] yuv;
    logic        skin;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t m;

  int checks = 0;
  int failures = 0;

  logic          pref_b = 1'b0;
  logic [CW-1:0] exp_a = '0, exp_b = '0;
  logic [CW-1:0] exp_sa = '0, exp_sb = '0;
  logic [53:0]   pa_cur, pb_cur;
  int            pix = 0;
  int            last_x = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [53:0] mkpix(input int n);
    logic [17:0] r, g, b;
    r = 18'(n * 37 + 11);
    g = 18'(n * 53 + 200);
    b = 18'(-(n * 71) - 5);
    return {r, g, b};
  endfunction

  function automatic logic skin_m(input logic [7:0] u,
                                  input logic [7:0] v);
    return (u >= 8'd73) && (u <= 8'd122) &&
           (v >= 8'd132) && (v <= 8'd173);
  endfunction

  // monitor: pop and compare whenever a result is presented
  always @(negedge clk) begin
    if (rst_n && (bus.ya_valid || bus.yb_valid)) begin
      chk("overlap", 64'(bus.ya_valid & bus.yb_valid), 64'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_valid actual=ya%0b/yb%0b required=none",
                 bus.ya_valid, bus.yb_valid);
      end else begin
        m = q.pop_front();
        chk("src", 64'(bus.yb_valid), 64'(m.src));
        chk("yuv", 64'(bus.yb_valid ? bus.yb_yuv : bus.ya_yuv),
            64'(m.yuv));
        chk("latency_cyc", 64'(cyc), 64'(m.at));
`ifdef RGBYUV_SCHED_SKIN_EN
        chk("skin", 64'(bus.yb_valid ? bus.yb_skin : bus.ya_skin),
            64'(m.skin));
`endif
      end
    end
  end

  task automatic drive(input logic av, input logic bv,
                       input logic fl, input logic en);
    logic        ga, gb;
    logic [53:0] px;
    exp_t        e;
    @(negedge clk);
    bus.a_valid = av;
    bus.b_valid = bv;
    bus.a_rgb   = pa_cur;
    bus.b_rgb   = pb_cur;
    flush       = fl;
    #1;
    ga = en && av && (!bv || !pref_b);
    gb = en && bv && (!av || pref_b);
    chk("a_ready", 64'(bus.a_ready), 64'(ga));
    chk("b_ready", 64'(bus.b_ready), 64'(gb));
    if (ga || gb) begin
      px     = gb ? pb_cur : pa_cur;
      e.src  = gb;
      e.yuv  = {px[43:36], px[25:18], px[7:0]};
      e.skin = skin_m(px[25:18], px[7:0]);
      e.at   = cyc + 1 + LAT;
      q.push_back(e);
      pref_b = ga;
      last_x = cyc;
      if (gb) begin
        exp_b++;
        if (e.skin) exp_sb++;
        pb_cur = mkpix(pix++);
      end else begin
        exp_a++;
        if (e.skin) exp_sa++;
        pa_cur = mkpix(pix++);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pa_cur = mkpix(pix++);
    pb_cur = mkpix(pix++);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_rgb   = pa_cur;
    bus.b_rgb   = pb_cur;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    chk("rst_ya", 64'(bus.ya_valid), 64'd0);
    chk("rst_yb", 64'(bus.yb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("rst_cv_red", 64'(cv_red), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // A alone, five back-to-back pixels
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("a_only_cnt_a", 64'(cnt_a), 64'd5);
    chk("a_only_cnt_b", 64'(cnt_b), 64'd0);
    chk("a_only_busy", 64'(busy), 64'd0);

    // both valid: alternating grants
    repeat (8) drive(1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    chk("rr_cnt_a", 64'(cnt_a), 64'd9);
    chk("rr_cnt_b", 64'(cnt_b), 64'd4);

    // flush with three pixels in flight
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      chk("flush_done", 64'(flush_done),
          64'(cyc >= last_x + LAT + 2));
    end
    chk("flush_results", 64'(q.size()), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_hold", 64'(flush_done), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("resume_done", 64'(flush_done), 64'd0);
    drain();
    chk("flush_cnt_a", 64'(cnt_a), 64'(exp_a));
    chk("flush_cnt_a_abs", 64'(cnt_a), 64'd13);

    // reset mid-stream with two pixels in flight
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("mid_rst_ya", 64'(bus.ya_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("mid_rst_cv_red", 64'(cv_red), 64'd0);
    q.delete();
    exp_a = '0;
    exp_b = '0;
    exp_sa = '0;
    exp_sb = '0;
    pref_b = 1'b0;
    bus.a_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_cnt_a", 64'(cnt_a), 64'd0);

    // counter wrap
    repeat (65535) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("cnt_a_full", 64'(cnt_a), 64'hFFFF);
    chk("cnt_a_full_m", 64'(cnt_a), 64'(exp_a));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("cnt_a_wrap", 64'(cnt_a), 64'h0000);

`ifdef RGBYUV_SCHED_SKIN_EN
    pa_cur = {18'd5, 18'd73, 18'd173};
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    pa_cur = {18'd6, 18'd72, 18'd173};
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    pa_cur = {18'd7, 18'd122, 18'd132};
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    pa_cur = {18'd8, 18'd123, 18'd150};
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("skin_a", 64'(skin_a), 64'(exp_sa));
    chk("skin_b", 64'(skin_b), 64'(exp_sb));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
